alu_muldiv: RTL

Next-generation execute-stage ALU for the MIPS core. It widens the op field and adds SRA, SLTU and LUI as single-cycle ops. It also adds a multi-cycle multiply/divide unit with architectural HI/LO registers, supporting MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. Single-cycle results are combinational. Mult/div run iteratively behind a busy flag that the hazard unit uses to stall the pipeline.

---
 rtl/alu_muldiv_pkg.sv | 35 +++
 rtl/muldiv_iter.sv | 108 ++++++++++
 rtl/alu_muldiv.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared op-code, FSM-state and constant definitions for the execute-stage ALU
// and its iterative multiply/divide unit.
package alu_muldiv_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_AND   = 5'b00000;
  localparam logic [OP_W-1:0] OP_OR    = 5'b00001;
  localparam logic [OP_W-1:0] OP_ADD   = 5'b00010;
  localparam logic [OP_W-1:0] OP_SLL   = 5'b00011;
  localparam logic [OP_W-1:0] OP_SRL   = 5'b00100;
  localparam logic [OP_W-1:0] OP_SRA   = 5'b00101;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SLT   = 5'b00111;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'b01000;
  localparam logic [OP_W-1:0] OP_LUI   = 5'b01001;
  localparam logic [OP_W-1:0] OP_NOR   = 5'b01100;
  localparam logic [OP_W-1:0] OP_XOR   = 5'b01101;
  localparam logic [OP_W-1:0] OP_MULT  = 5'b10000;
  localparam logic [OP_W-1:0] OP_MULTU = 5'b10001;
  localparam logic [OP_W-1:0] OP_DIV   = 5'b10010;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'b10011;
  localparam logic [OP_W-1:0] OP_MFHI  = 5'b10100;
  localparam logic [OP_W-1:0] OP_MFLO  = 5'b10101;
  localparam logic [OP_W-1:0] OP_MTHI  = 5'b10110;
  localparam logic [OP_W-1:0] OP_MTLO  = 5'b10111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Wide enough for any supported datapath; users slice the low NBITS.
  localparam logic [127:0] ALL_ONES = '1;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide: one shift-add or restoring-subtract step per cycle
// on operand magnitudes, then a single sign-fix cycle that presents HI/LO.
module muldiv_iter
  import alu_muldiv_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int CBITS = 6,
  parameter int BOP   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BOP-1:0]   op,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             wr,
  output logic [NBITS-1:0] hi,
  output logic [NBITS-1:0] lo
);

  localparam int PW = 2 * NBITS;

  function automatic logic [NBITS-1:0] neg_if(input logic [NBITS-1:0] v, input logic neg);
    return neg ? (~v + NBITS'(1)) : v;
  endfunction

  logic [1:0]         state;
  logic [CBITS-1:0]   cnt;
  logic               is_div, neg_q, neg_r, b_zero;
  logic [NBITS-1:0]   acc_hi, acc_lo, opnd;
  logic               signed_op, sign_a, sign_b;
  logic [NBITS:0]     add_sum, shifted, diff;
  logic [PW-1:0]      prod, prod_fix;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign sign_a    = signed_op & a[NBITS-1];
  assign sign_b    = signed_op & b[NBITS-1];

  assign add_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {NBITS{1'b0}})};
  assign shifted  = {acc_hi, acc_lo[NBITS-1]};
  assign diff     = shifted - {1'b0, opnd};
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? (~prod + PW'(1)) : prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_CALC;
          cnt   <= CBITS'(NBITS - 1);
        end
        ST_CALC: begin
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - CBITS'(1);
        end
        ST_FIX: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Accumulator: acc_lo starts as |A| and is shifted out (mult) or becomes the quotient (div)
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      is_div <= (op == OP_DIV) || (op == OP_DIVU);
      neg_q  <= sign_a ^ sign_b;
      neg_r  <= sign_a;
      b_zero <= (b == '0);
      acc_hi <= '0;
      acc_lo <= neg_if(a, sign_a);
      opnd   <= neg_if(b, sign_b);
    end else if (state == ST_CALC) begin
      if (!is_div) begin
        {acc_hi, acc_lo} <= {add_sum, acc_lo[NBITS-1:1]};
      end else if (!diff[NBITS]) begin
        acc_hi <= diff[NBITS-1:0];
        acc_lo <= {acc_lo[NBITS-2:0], 1'b1};
      end else begin
        acc_hi <= shifted[NBITS-1:0];
        acc_lo <= {acc_lo[NBITS-2:0], 1'b0};
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign wr   = (state == ST_FIX);

  // Divide by zero leaves |A| in the remainder, so only the quotient needs overriding
  always_comb begin
    if (is_div) begin
      lo = b_zero ? ALL_ONES[NBITS-1:0] : neg_if(acc_lo, neg_q);
      hi = neg_if(acc_hi, neg_r);
    end else begin
      {hi, lo} = prod_fix;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational single-cycle ops plus architectural HI/LO
// fed by MTHI/MTLO and by the iterative multiply/divide unit.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int RNBITS = 5,
  parameter int BOP    = 5,
  parameter int CBITS  = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_Valid,
  input  logic [NBITS-1:0]  i_Reg,
  input  logic [NBITS-1:0]  i_Mux,
  input  logic [RNBITS-1:0] i_Shamt,
  input  logic [BOP-1:0]    i_Op,
  output logic [NBITS-1:0]  o_Result,
  output logic              o_Cero,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [NBITS-1:0]  o_Hi,
  output logic [NBITS-1:0]  o_Lo
);

  logic [NBITS-1:0]        hi_reg, lo_reg, md_hi, md_lo;
  logic                    md_busy, md_wr, is_muldiv, start, mt_hi, mt_lo;
  logic signed [NBITS-1:0] a_s, b_s;

  assign a_s = i_Reg;
  assign b_s = i_Mux;

  assign is_muldiv = (i_Op == OP_MULT) || (i_Op == OP_MULTU) ||
                     (i_Op == OP_DIV)  || (i_Op == OP_DIVU);
  assign start = i_Valid && is_muldiv && !md_busy;
  assign mt_hi = i_Valid && (i_Op == OP_MTHI) && !md_busy;
  assign mt_lo = i_Valid && (i_Op == OP_MTLO) && !md_busy;

  muldiv_iter #(
    .NBITS(NBITS),
    .CBITS(CBITS),
    .BOP  (BOP)
  ) u_muldiv (
    .clk  (i_clk),
    .reset(i_reset),
    .start(start),
    .op   (i_Op),
    .a    (i_Reg),
    .b    (i_Mux),
    .busy (md_busy),
    .done (o_Done),
    .wr   (md_wr),
    .hi   (md_hi),
    .lo   (md_lo)
  );

  // MTHI/MTLO can never coincide with a mult/div write-back since both need IDLE vs FIX
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (md_wr) begin
      hi_reg <= md_hi;
      lo_reg <= md_lo;
    end else begin
      if (mt_hi) hi_reg <= i_Reg;
      if (mt_lo) lo_reg <= i_Reg;
    end
  end

  always_comb begin
    o_Result = ALL_ONES[NBITS-1:0];
    case (i_Op)
      OP_AND:  o_Result = i_Reg & i_Mux;
      OP_OR:   o_Result = i_Reg | i_Mux;
      OP_ADD:  o_Result = i_Reg + i_Mux;
      OP_SUB:  o_Result = i_Reg - i_Mux;
      OP_NOR:  o_Result = ~(i_Reg | i_Mux);
      OP_XOR:  o_Result = i_Reg ^ i_Mux;
      OP_SLL:  o_Result = i_Mux << i_Shamt;
      OP_SRL:  o_Result = i_Mux >> i_Shamt;
      OP_SRA:  o_Result = b_s >>> i_Shamt;
      OP_SLT:  o_Result = {{(NBITS-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: o_Result = {{(NBITS-1){1'b0}}, (i_Reg < i_Mux)};
      OP_LUI:  o_Result = i_Mux << (NBITS / 2);
      OP_MFHI: o_Result = hi_reg;
      OP_MFLO: o_Result = lo_reg;
      default: o_Result = ALL_ONES[NBITS-1:0];
    endcase
  end

  assign o_Cero = (o_Result == '0);
  assign o_Busy = md_busy;
  assign o_Hi   = hi_reg;
  assign o_Lo   = lo_reg;

endmodule
